// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants, state encoding and framebuffer address helper for the VGA fetch path
package vga_pkg;

    localparam int H_ACTIVE_DEFAULT = 640;
    localparam int V_ACTIVE_DEFAULT = 480;
    localparam int FB_WIDTH         = 160;
    localparam int FB_HEIGHT        = 120;
    localparam int ADDR_W           = 15;

    typedef enum logic {
        SYNC_WAIT = 1'b0,
        RUN       = 1'b1
    } fetch_state_t;

    // row*160 + col as row*128 + row*32 + col, so no multiplier is inferred
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [9:0] row, input logic [9:0] col);
        logic [ADDR_W-1:0] row_w;
        logic [ADDR_W-1:0] col_w;
        row_w = {5'b0, row};
        col_w = {5'b0, col};
        return (row_w << 7) + (row_w << 5) + col_w;
    endfunction

endpackage

// File: rtl/vga_rgb332_expand.sv
// rtl/vga_rgb332_expand.sv - combinational RGB332 to RGB444 expansion by bit replication
module vga_rgb332_expand (
    input  logic [7:0]  rgb332,
    output logic [11:0] rgb444
);

    assign rgb444 = {rgb332[7:5], rgb332[7],
                     rgb332[4:2], rgb332[4],
                     rgb332[1:0], rgb332[1:0]};

endmodule

// File: rtl/vga_pixel_fetch.sv
// rtl/vga_pixel_fetch.sv - two-stage framebuffer fetch and colour output; optional white border with VGA_FETCH_BORDER_EN
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEFAULT,
    parameter int V_ACTIVE    = V_ACTIVE_DEFAULT,
    parameter int SCALE_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        xpos,
    input  logic [9:0]        ypos,
    input  logic              HSync_in,
    input  logic              VSync_in,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_en,
    input  logic [7:0]        vram_data,
    output logic              HSync,
    output logic              VSync,
    output logic [3:0]        r,
    output logic [3:0]        g,
    output logic [3:0]        b,
    output logic [7:0]        frame_cnt
);

    localparam logic [9:0] H_LIM  = 10'(H_ACTIVE);
    localparam logic [9:0] V_LIM  = 10'(V_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE - 1);

    fetch_state_t      state;
    fetch_state_t      state_next;

    logic              active;
    logic              on_border;
    logic [9:0]        row;
    logic [9:0]        col;
    logic [ADDR_W-1:0] addr_calc;
    logic              hs_q;
    logic              vs_q;
    logic              border_q;
    logic              vs_rise;
    logic              vs_fall;
    logic [11:0]       rgb444;
    logic [11:0]       pix_next;

    assign active    = (xpos < H_LIM) && (ypos < V_LIM);
    assign row       = ypos >> SCALE_SHIFT;
    assign col       = xpos >> SCALE_SHIFT;
    assign addr_calc = fb_addr(row, col);

`ifdef VGA_FETCH_BORDER_EN
    assign on_border = (xpos == 10'd0) || (xpos == H_LAST) ||
                       (ypos == 10'd0) || (ypos == V_LAST);
`else
    assign on_border = 1'b0;
`endif

    // vs_q is both the edge-detect reference and the first sync delay stage
    assign vs_rise = VSync_in & ~vs_q;
    assign vs_fall = ~VSync_in & vs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SYNC_WAIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SYNC_WAIT: if (vs_rise) state_next = RUN;
            RUN:       state_next = RUN;
            default:   state_next = SYNC_WAIT;
        endcase
    end

    // Stage 1: address, enable and sync capture
    always_ff @(posedge clk) begin
        if (rst) begin
            vram_en   <= 1'b0;
            vram_addr <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            border_q  <= 1'b0;
        end else begin
            vram_en  <= active && (state == RUN);
            hs_q     <= HSync_in;
            vs_q     <= VSync_in;
            border_q <= active && on_border;
            // Off-screen coordinates would overflow the address, so hold instead
            if (active) begin
                vram_addr <= addr_calc;
            end
        end
    end

    vga_rgb332_expand u_expand (
        .rgb332 (vram_data),
        .rgb444 (rgb444)
    );

    always_comb begin
        pix_next = 12'h000;
        if (vram_en && (state == RUN)) begin
            pix_next = border_q ? 12'hFFF : rgb444;
        end
    end

    // Stage 2: colour and aligned syncs
    always_ff @(posedge clk) begin
        if (rst) begin
            r     <= 4'h0;
            g     <= 4'h0;
            b     <= 4'h0;
            HSync <= 1'b1;
            VSync <= 1'b1;
        end else begin
            r     <= pix_next[11:8];
            g     <= pix_next[7:4];
            b     <= pix_next[3:0];
            HSync <= hs_q;
            VSync <= vs_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= 8'd0;
        end else if ((state == RUN) && vs_fall) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb/tb_vga_pixel_fetch.sv - randomized scoreboard bench for vga_pixel_fetch against a frame-level reference model
module tb_vga_pixel_fetch;

    localparam int H   = 640;
    localparam int V   = 480;
    localparam int FB  = 160 * 120;
    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  xpos;
    logic [9:0]  ypos;
    logic        HSync_in;
    logic        VSync_in;
    logic [14:0] vram_addr;
    logic        vram_en;
    logic [7:0]  vram_data;
    logic        HSync;
    logic        VSync;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic [7:0]  frame_cnt;

    always #5 clk = ~clk;

    vga_pixel_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .xpos      (xpos),
        .ypos      (ypos),
        .HSync_in  (HSync_in),
        .VSync_in  (VSync_in),
        .vram_addr (vram_addr),
        .vram_en   (vram_en),
        .vram_data (vram_data),
        .HSync     (HSync),
        .VSync     (VSync),
        .r         (r),
        .g         (g),
        .b         (b),
        .frame_cnt (frame_cnt)
    );

    typedef struct {
        int          tag;
        logic        en;
        logic [14:0] addr;
        logic        chk_addr;
        logic [7:0]  frames;
    } s1_t;

    typedef struct {
        int          tag;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } s2_t;

    s1_t        s1_q[$];
    s2_t        s2_q[$];
    logic [7:0] mem [FB];
    bit         rst_hist [MAXC];
    int         cycle  = 0;
    int         n_vec  = 0;
    int         n_bad  = 0;
    bit         done   = 0;

    bit m_run;
    bit m_prev_vs;
    int m_frames;

    function automatic logic [11:0] expand(input logic [7:0] d);
        return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
    endfunction

    function automatic int rx();
        return int'($urandom_range(0, 799));
    endfunction

    function automatic int ry();
        return int'($urandom_range(0, 524));
    endfunction

    task automatic chk(input string nm, input int e, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, e, act, exp);
        end
    endtask

    // Reference model: what the display should show for the pixel presented this cycle
    task automatic drive(input bit rs, input int x, input int y, input bit hs, input bit vs);
        s1_t e1;
        s2_t e2;
        bit  act;
        bit  run_before;
        int  a;
        rst      = rs;
        xpos     = 10'(x);
        ypos     = 10'(y);
        HSync_in = hs;
        VSync_in = vs;
        rst_hist[cycle] = rs;
        act    = (x < H) && (y < V);
        e1.tag = cycle;
        e2.tag = cycle;
        if (rs) begin
            m_run = 0; m_prev_vs = 1; m_frames = 0;
            e1.en = 0; e1.addr = 15'd0; e1.chk_addr = 1; e1.frames = 8'd0;
            e2.rgb = 12'h000; e2.hs = 1; e2.vs = 1;
        end else begin
            run_before  = m_run;
            a           = (y / 4) * 160 + (x / 4);
            e1.en       = act && run_before;
            e1.addr     = 15'(a);
            e1.chk_addr = e1.en;
            e2.rgb      = 12'h000;
            if (e1.en) begin
                e2.rgb = expand(mem[a]);
`ifdef VGA_FETCH_BORDER_EN
                if (x == 0 || x == H - 1 || y == 0 || y == V - 1) e2.rgb = 12'hFFF;
`endif
            end
            if (run_before && m_prev_vs && !vs) m_frames = (m_frames + 1) % 256;
            if (!run_before && !m_prev_vs && vs) m_run = 1;
            m_prev_vs = vs;
            e1.frames = 8'(m_frames);
            e2.hs     = hs;
            e2.vs     = vs;
        end
        s1_q.push_back(e1);
        s2_q.push_back(e2);
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic drive_rand(input bit vs);
        drive(0, rx(), ry(), 1'($urandom_range(0, 1)), vs);
    endtask

    // VRAM with one cycle read latency; garbage when not enabled
    initial begin
        vram_data = 8'h00;
        forever begin
            @(negedge clk);
            if (vram_en && int'(vram_addr) < FB) vram_data = mem[vram_addr];
            else vram_data = 8'($urandom);
        end
    end

    initial begin
        int  e;
        s1_t a1;
        s2_t a2;
        e = 0;
        forever begin
            @(posedge clk);
            @(negedge clk);
            if (!done) begin
                if (s1_q.size() > 0 && s1_q[0].tag == e) begin
                    a1 = s1_q.pop_front();
                    chk("vram_en", e, 32'(vram_en), 32'(a1.en));
                    if (a1.chk_addr) chk("vram_addr", e, 32'(vram_addr), 32'(a1.addr));
                    chk("frame_cnt", e, 32'(frame_cnt), 32'(a1.frames));
                end else begin
                    chk("scoreboard_s1", e, 32'(s1_q.size()), 32'(1));
                end
                if (rst_hist[e]) begin
                    chk("rgb_reset", e, 32'({r, g, b}), 32'h0);
                    chk("hsync_reset", e, 32'(HSync), 32'h1);
                    chk("vsync_reset", e, 32'(VSync), 32'h1);
                    if (s2_q.size() > 0 && s2_q[0].tag == e - 1) void'(s2_q.pop_front());
                end else if (s2_q.size() > 0 && s2_q[0].tag == e - 1) begin
                    a2 = s2_q.pop_front();
                    chk("rgb", e, 32'({r, g, b}), 32'(a2.rgb));
                    chk("hsync", e, 32'(HSync), 32'(a2.hs));
                    chk("vsync", e, 32'(VSync), 32'(a2.vs));
                end
            end
            e++;
        end
    end

    initial begin
        for (int i = 0; i < FB; i++) mem[i] = 8'($urandom);
        mem[321]  = 8'hE0;
        mem[8000] = 8'h00;
        m_run = 0; m_prev_vs = 1; m_frames = 0;

        repeat (3) drive(1, rx(), ry(), 1, 1);
        // Waiting for sync: no colour, and this falling edge is not a frame
        repeat (4) drive(0, 10, 10, 1, 1);
        repeat (3) drive_rand(0);
        drive(0, 5, 9, 1, 1);

        drive(0, 5, 9, 1, 1);
        drive(0, 639, 479, 0, 1);
        drive(0, 700, 9, 1, 1);
        drive(0, 0, 200, 1, 1);
        drive(0, 639, 0, 1, 1);
        drive(0, 320, 479, 1, 1);

        for (int f = 0; f < 3; f++) begin
            repeat (2) drive_rand(0);
            repeat (5) drive_rand(1);
        end
        for (int f = 0; f < 253; f++) begin
            drive_rand(0);
            drive_rand(1);
        end

        drive(0, 299, 100, 0, 1);
        drive(1, 300, 100, 0, 0);
        repeat (6) drive(0, 40, 40, 0, 1);
        repeat (2) drive_rand(0);
        drive(0, 40, 40, 1, 1);
        repeat (30) drive_rand(1);

        repeat (200) drive_rand($urandom_range(0, 9) != 0);

        repeat (2) drive(0, 0, 0, 1, 1);
        done = 1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_pixel_fetch.md
VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-003 SHALL have parameter SCALE_SHIFT, default 2: log2 of the pixel-replication factor, giving a 160x120 framebuffer.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, the same pixel clock that drives vga_sync.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have ports xpos and ypos, input, 10 bits each: pixel coordinates from vga_sync.
REQ-007 SHALL have ports HSync_in and VSync_in, input, 1 bit each: active-low syncs from vga_sync.
REQ-008 SHALL have port vram_addr, output, 15 bits: framebuffer read address.
REQ-009 SHALL have port vram_en, output, 1 bit: read enable.
REQ-010 SHALL have port vram_data, input, 8 bits: RGB332 word, valid 1 cycle after vram_en.
REQ-011 SHALL have ports HSync and VSync, output, 1 bit each: syncs delayed to align with the colour outputs.
REQ-012 SHALL have ports r, g and b, output, 4 bits each: pixel colour.
REQ-013 SHALL have port frame_cnt, output, 8 bits: count of completed frames.

Function
REQ-014 SHALL treat a pixel as active iff xpos < H_ACTIVE and ypos < V_ACTIVE.
REQ-015 SHALL compute vram_addr = (ypos>>SCALE_SHIFT)*160 + (xpos>>SCALE_SHIFT) using only shifts and adds (row*128 + row*32 + col); no multiplier.
REQ-016 SHALL register vram_addr and vram_en in stage 1; vram_en = active AND state==RUN.
REQ-017 SHALL register r, g and b in stage 2; total latency from xpos/ypos to colour SHALL be 2 cycles.
REQ-018 SHALL delay HSync_in and VSync_in through the same 2 stages so that the syncs stay aligned with the colour.
REQ-019 SHALL expand RGB332 to 4 bits per channel: r={d[7:5],d[7]}, g={d[4:2],d[4]}, b={d[1:0],d[1:0]}.
REQ-020 SHALL drive r/g/b = 0 for any inactive pixel, or whenever state != RUN, at the corresponding stage-2 cycle.
REQ-021 SHALL implement FSM SYNC_WAIT -> RUN: leave SYNC_WAIT on the first VSync_in rising edge (end of pulse); RUN holds until reset.
REQ-022 SHALL increment frame_cnt on every VSync_in falling edge while in RUN; it SHALL wrap 255 -> 0.
REQ-023 SHALL detect edges against a registered copy of VSync_in; the edge-detect register SHALL also feed the sync delay line.
REQ-024 SHALL leave vram_addr holding its last value when vram_en=0; this value is don't-care to the consumer.
REQ-025 SHALL give xpos/ypos values at or above the active limits inactive status only; they SHALL never cause address overflow.

Reset
REQ-026 SHALL, on rst=1 at a clk edge, set: state=SYNC_WAIT, vram_en=0, vram_addr=0, r/g/b=0, HSync=1, VSync=1, frame_cnt=0, sync delay lines=1, and the edge register=1.
REQ-027 SHALL, when reset is asserted mid-frame, blank the outputs from the next edge; output resumes only after the next VSync_in rising edge.

Configuration
REQ-028 SHALL, with macro VGA_FETCH_BORDER_EN defined, output white (F,F,F) at x=0, x=H_ACTIVE-1, y=0 and y=V_ACTIVE-1 in RUN, overriding vram_data, with the same latency.
REQ-029 SHALL, without VGA_FETCH_BORDER_EN, output vram_data-derived colour for all active pixels.

Structure
REQ-030 SHALL place H_ACTIVE/V_ACTIVE defaults, FB_WIDTH=160, FB_HEIGHT=120, the state encoding (SYNC_WAIT=0, RUN=1) and the address width (15) in shared package vga_pkg.
REQ-031 SHALL implement the RGB332 expansion as sub-module vga_rgb332_expand (combinational, 8 in, 12 out), instantiated once.

Verification
REQ-032 SHALL verify reset then VSync_in low->high: state RUN on the following cycle, and frame_cnt=0.
REQ-033 SHALL verify, in RUN, xpos=5 and ypos=9: vram_addr=2*160+1=321 with vram_en=1 one cycle later; vram_data=8'hE0 yields r=F, g=0, b=0 two cycles after the input.
REQ-034 SHALL verify xpos=639, ypos=479 gives vram_addr=119*160+159=19199; xpos=700 gives vram_en=0 and r/g/b=0.
REQ-035 SHALL verify three VSync_in falling edges in RUN give frame_cnt=3; 256 edges give frame_cnt=0.
REQ-036 SHALL verify rst=1 asserted mid-line at xpos=300: next cycle r/g/b=0 and HSync=VSync=1; output stays blank until a VSync_in rising edge.
REQ-037 SHALL verify, with VGA_FETCH_BORDER_EN, xpos=0, ypos=200 and vram_data=0: r=g=b=F at 2-cycle latency; without the macro: 0.
